// File: rtl/alu_useq.sv
// Microcode sequencer for the Koblitz-curve ALU accumulator datapath.
// Fetches from a synchronous micro-ROM and drives the ALU control bundle in EXEC.
module alu_useq #(
  parameter int AW = 8,
  parameter int UW = 43
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] entry_addr,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic          urom_en,
  output logic [AW-1:0] uaddr,
  input  logic [UW-1:0] udata,
  input  logic          LSB_store,
  input  logic          b0_one,
  input  logic          b1_zero,
  input  logic          M4_out0,
  output logic [8:0]    control_group1,
  output logic [13:0]   control_group2,
  output logic [1:0]    mode,
  output logic          sel4,
  output logic          sel5,
  output logic [2:0]    ROM_sel,
  output logic          rst_d_carry
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2} state_t;

  localparam logic [3:0] OP_NEXT  = 4'd0;
  localparam logic [3:0] OP_JMP   = 4'd1;
  localparam logic [3:0] OP_BLSB  = 4'd2;
  localparam logic [3:0] OP_BTERM = 4'd3;
  localparam logic [3:0] OP_BM4   = 4'd4;
  localparam logic [3:0] OP_LDC   = 4'd5;
  localparam logic [3:0] OP_DJNZ  = 4'd6;
  localparam logic [3:0] OP_CALL  = 4'd7;
  localparam logic [3:0] OP_RET   = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd9;

  state_t        state_q, state_d;
  logic [AW-1:0] uaddr_q, uaddr_d;
  logic [AW-1:0] ret_q, ret_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          busy_q, busy_d;
  logic          urom_en_q, urom_en_d;

  logic [3:0]    op_s;
  logic [AW-1:0] tgt_s;
  logic [AW-1:0] nxt_s;
  logic [7:0]    cnt_dec_s;
  logic [30:0]   dp_s;
  logic          exec_s;

  assign op_s      = udata[42:39];
  assign tgt_s     = udata[31 +: AW];
  assign nxt_s     = uaddr_q + AW'(1);
  assign cnt_dec_s = cnt_q - 8'd1;
  assign exec_s    = (state_q == S_EXEC);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      uaddr_q   <= '0;
      ret_q     <= '0;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      urom_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      uaddr_q   <= uaddr_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
      urom_en_q <= urom_en_d;
    end
  end

  // Next state and next microaddress; uaddr holds the executing address through EXEC
  always_comb begin
    state_d   = state_q;
    uaddr_d   = uaddr_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    urom_en_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          uaddr_d   = entry_addr;
          urom_en_d = 1'b1;
          illegal_d = 1'b0;
          state_d   = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d   = S_FETCH;
        urom_en_d = 1'b1;
        case (op_s)
          OP_NEXT:  uaddr_d = nxt_s;
          OP_JMP:   uaddr_d = tgt_s;
          OP_BLSB:  uaddr_d = LSB_store ? tgt_s : nxt_s;
          OP_BTERM: uaddr_d = (b0_one && b1_zero) ? tgt_s : nxt_s;
          OP_BM4:   uaddr_d = M4_out0 ? tgt_s : nxt_s;
          OP_LDC: begin
            cnt_d   = udata[38:31];
            uaddr_d = nxt_s;
          end
          OP_DJNZ: begin
            cnt_d   = cnt_dec_s;
            uaddr_d = (cnt_dec_s != 8'd0) ? tgt_s : nxt_s;
          end
          OP_CALL: begin
            ret_d   = nxt_s;
            uaddr_d = tgt_s;
          end
          OP_RET:   uaddr_d = ret_q;
          OP_HALT: begin
            state_d   = S_IDLE;
            urom_en_d = 1'b0;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_IDLE;
            urom_en_d = 1'b0;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Output decode: the datapath field is live only in EXEC, FETCH is a NOP
  always_comb begin
    dp_s = 31'd0;
    done = 1'b0;
    if (exec_s) begin
      dp_s = udata[30:0];
      done = (op_s == OP_HALT);
    end else begin
      dp_s = 31'd0;
      done = 1'b0;
    end
  end

  assign control_group1 = dp_s[30:22];
  assign control_group2 = dp_s[21:8];
  assign mode           = dp_s[7:6];
  assign sel4           = dp_s[5];
  assign sel5           = dp_s[4];
  assign ROM_sel        = dp_s[3:1];
  assign rst_d_carry    = dp_s[0];
  assign uaddr          = uaddr_q;
  assign busy           = busy_q;
  assign illegal        = illegal_q;
  assign urom_en        = urom_en_q;

endmodule
